// File: rtl/clock_pkg.sv
// clock_pkg: shared widths, limits, mode encoding and wrap helpers for the clock set controller
package clock_pkg;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int HOURS_W     = 5;
  localparam int MINUTES_W   = 6;
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_ALM} mode_e;
  function automatic logic [HOURS_W-1:0] inc_h(input logic [HOURS_W-1:0] h);
    return (h == HOURS_W'(HOURS_MAX)) ? '0 : h + 1'b1;
  endfunction
  function automatic logic [MINUTES_W-1:0] inc_m(input logic [MINUTES_W-1:0] m);
    return (m == MINUTES_W'(MINUTES_MAX)) ? '0 : m + 1'b1;
  endfunction
  function automatic logic [HOURS_W-1:0] clamp_h(input logic [HOURS_W-1:0] h);
    return (h > HOURS_W'(HOURS_MAX)) ? '0 : h;
  endfunction
  function automatic logic [MINUTES_W-1:0] clamp_m(input logic [MINUTES_W-1:0] m);
    return (m > MINUTES_W'(MINUTES_MAX)) ? '0 : m;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: 1 s tick while running, half-period blink phase while editing.
// Any change of run restarts the count, so the first tick comes TICK_DIV cycles after resuming.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick_1s,
  output logic blink
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic r_run, r_tick, r_blink, w_restart, w_wrap;
  assign w_restart = run != r_run;
  assign w_wrap    = r_cnt == CW'(TICK_DIV - 1);
  assign w_cnt_n   = (w_restart || w_wrap) ? '0 : r_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_run   <= run;
      r_cnt   <= w_cnt_n;
      r_tick  <= run && w_cnt_n == CW'(TICK_DIV - 1);
      r_blink <= (run || w_restart) ? 1'b0 : r_blink ^ (r_cnt == CW'(TICK_DIV / 2 - 1) || w_wrap);
    end
  end
  assign tick_1s = r_tick;
  assign blink   = r_blink;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: tick generation and button-driven set-time FSM for the HH:MM:SS counter.
// Define CLOCK_ALARM_EN to add alarm editing, arming and dismiss.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_mode,
  input  logic                 btn_inc,
  input  logic [HOURS_W-1:0]   cur_hours,
  input  logic [MINUTES_W-1:0] cur_minutes,
  output logic                 tick_1s,
  output logic                 load,
  output logic [HOURS_W-1:0]   load_hours,
  output logic [MINUTES_W-1:0] load_minutes,
  output logic [1:0]           edit_mode,
  output logic                 blink
`ifdef CLOCK_ALARM_EN
  ,
  output logic                 alarm,
  output logic                 alarm_armed
`endif
);
`ifdef CLOCK_ALARM_EN
  localparam mode_e AFTER_MIN = SET_ALM;
`else
  localparam mode_e AFTER_MIN = RUN;
`endif
  mode_e r_state, w_state_n;
  logic [HOURS_W-1:0] r_edit_h, w_edit_h_n, r_load_h;
  logic [MINUTES_W-1:0] r_edit_m, w_edit_m_n, r_load_m;
  logic r_load, w_leave, w_hold, w_blink;
`ifdef CLOCK_ALARM_EN
  logic [HOURS_W-1:0] r_alm_h, w_alm_h_n;
  logic [MINUTES_W-1:0] r_alm_m, w_alm_m_n;
  logic r_alm_sub, w_alm_sub_n, r_armed, w_armed_n, r_dismiss, w_dismiss_n, r_alarm, w_alarm_n;
  // A mode press while ringing only silences; it does not enter editing.
  assign w_hold      = r_alarm;
  assign w_dismiss_n = (r_state == RUN && btn_mode && r_alarm) || (r_dismiss && cur_minutes == r_alm_m);
  assign w_alarm_n   = w_state_n == RUN && w_armed_n && cur_hours == w_alm_h_n
                       && cur_minutes == w_alm_m_n && !w_dismiss_n;
  assign alarm       = r_alarm;
  assign alarm_armed = r_armed;
`else
  assign w_hold = 1'b0;
`endif
  assign w_leave = r_state == SET_MIN && btn_mode;
  always_comb begin
    w_state_n  = r_state;
    w_edit_h_n = r_edit_h;
    w_edit_m_n = r_edit_m;
`ifdef CLOCK_ALARM_EN
    w_alm_sub_n = r_alm_sub;
    w_alm_h_n   = r_alm_h;
    w_alm_m_n   = r_alm_m;
    w_armed_n   = r_armed;
`endif
    case (r_state)
      RUN: if (btn_mode && !w_hold) begin
        w_state_n  = SET_HR;
        w_edit_h_n = clamp_h(cur_hours);
        w_edit_m_n = clamp_m(cur_minutes);
      end
      SET_HR:  if (btn_mode) w_state_n = SET_MIN; else if (btn_inc) w_edit_h_n = inc_h(r_edit_h);
      SET_MIN: if (btn_mode) w_state_n = AFTER_MIN; else if (btn_inc) w_edit_m_n = inc_m(r_edit_m);
      default: begin
`ifdef CLOCK_ALARM_EN
        if (btn_mode) begin
          w_alm_sub_n = !r_alm_sub;
          w_state_n   = r_alm_sub ? RUN : SET_ALM;
          w_armed_n   = r_armed || r_alm_sub;
        end else if (btn_inc) begin
          w_alm_h_n = r_alm_sub ? r_alm_h : inc_h(r_alm_h);
          w_alm_m_n = r_alm_sub ? inc_m(r_alm_m) : r_alm_m;
        end
`else
        w_state_n = RUN;
`endif
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_edit_h <= '0;
      r_edit_m <= '0;
      r_load   <= 1'b0;
      r_load_h <= '0;
      r_load_m <= '0;
`ifdef CLOCK_ALARM_EN
      r_alm_sub <= 1'b0;
      r_alm_h   <= '0;
      r_alm_m   <= '0;
      r_armed   <= 1'b0;
      r_dismiss <= 1'b0;
      r_alarm   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_edit_h <= w_edit_h_n;
      r_edit_m <= w_edit_m_n;
      r_load   <= w_leave;
      if (w_leave) begin
        r_load_h <= r_edit_h;
        r_load_m <= r_edit_m;
      end
`ifdef CLOCK_ALARM_EN
      r_alm_sub <= w_alm_sub_n;
      r_alm_h   <= w_alm_h_n;
      r_alm_m   <= w_alm_m_n;
      r_armed   <= w_armed_n;
      r_dismiss <= w_dismiss_n;
      r_alarm   <= w_alarm_n;
`endif
    end
  end
  // The prescaler sees RUN one cycle late, which also keeps it parked through the load cycle.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .run     (r_state == RUN),
    .tick_1s (tick_1s),
    .blink   (w_blink)
  );
  assign blink        = w_blink && r_state != RUN;
  assign load         = r_load;
  assign load_hours   = r_load_h;
  assign load_minutes = r_load_m;
  assign edit_mode    = r_state;
endmodule
